// File: rtl/sap1_control_sequencer_if.sv
// Control bus between the SAP-1 sequencer (master) and the datapath/IR/flags side (slave).
interface sap1_control_sequencer_if;
   logic       pr_mode;
   logic [3:0] opcode;
   logic [3:0] flags;
   logic       halt;
   logic       reg_a_in, reg_a_out, reg_b_in, reg_b_out;
   logic       alu_out, alu_sub;
   logic       instr_in, instr_out;
   logic       mar_in, ram_in, ram_out;
   logic       reg_out;
   logic       pc_inc, pc_out, pc_jmp;
   logic [3:0] reg_flags_in;
   logic [3:0] step_out;

   modport master (
      input  pr_mode, opcode, flags,
      output halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub,
             instr_in, instr_out, mar_in, ram_in, ram_out, reg_out,
             pc_inc, pc_out, pc_jmp, reg_flags_in, step_out
   );

   modport slave (
      output pr_mode, opcode, flags,
      input  halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub,
             instr_in, instr_out, mar_in, ram_in, ram_out, reg_out,
             pc_inc, pc_out, pc_jmp, reg_flags_in, step_out
   );
endinterface

// File: rtl/sap1_control_sequencer.sv
// SAP-1 T-step sequencer and control-strobe decoder.
// Optional macro SEQ_EARLY_END_EN: wrap to T0 after the last useful step of each instruction.
module sap1_control_sequencer (
   input logic                     clk,
   input logic                     rst,
   sap1_control_sequencer_if.master bus
);
   typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_e;

   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_STA = 4'd4;
   localparam logic [3:0] OP_LDI = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_JC  = 4'd7;
   localparam logic [3:0] OP_JZ  = 4'd8;
   localparam logic [3:0] OP_OUT = 4'd14;
   localparam logic [3:0] OP_HLT = 4'd15;

   step_e step_q, step_d, last_step;
   logic  halted_q, halted_d;
   logic  active, hlt_decode;

   always_ff @(posedge clk) begin
      if (!rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
`ifdef SEQ_EARLY_END_EN
      case (bus.opcode)
         OP_LDA, OP_STA: last_step = T3;
         OP_ADD, OP_SUB: last_step = T4;
         default:        last_step = T2;
      endcase
`else
      last_step = T4;
`endif
   end

   assign hlt_decode = (step_q == T2) && (bus.opcode == OP_HLT);

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (bus.pr_mode) begin
         step_d = T0;
      end else if (halted_q) begin
         step_d = step_q;
      end else if (hlt_decode) begin
         halted_d = 1'b1;
         step_d   = T2;
      end else if (step_q == last_step) begin
         step_d = T0;
      end else begin
         step_d = step_e'(step_q + 3'd1);
      end
   end

   // Strobes are live only when running; halt itself survives halted but not reset/programming.
   assign active = rst && !bus.pr_mode && !halted_q;

   always_comb begin
      bus.halt         = rst && !bus.pr_mode && (halted_q || hlt_decode);
      bus.reg_a_in     = 1'b0;
      bus.reg_a_out    = 1'b0;
      bus.reg_b_in     = 1'b0;
      bus.reg_b_out    = 1'b0;
      bus.alu_out      = 1'b0;
      bus.alu_sub      = 1'b0;
      bus.instr_in     = 1'b0;
      bus.instr_out    = 1'b0;
      bus.mar_in       = 1'b0;
      bus.ram_in       = 1'b0;
      bus.ram_out      = 1'b0;
      bus.reg_out      = 1'b0;
      bus.pc_inc       = 1'b0;
      bus.pc_out       = 1'b0;
      bus.pc_jmp       = 1'b0;
      bus.reg_flags_in = 4'b0000;
      bus.step_out     = rst ? {1'b0, step_q} : 4'd0;
      if (active) begin
         case (step_q)
            T0: begin
               bus.pc_out = 1'b1;
               bus.mar_in = 1'b1;
            end
            T1: begin
               bus.ram_out  = 1'b1;
               bus.instr_in = 1'b1;
               bus.pc_inc   = 1'b1;
            end
            T2: begin
               case (bus.opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     bus.instr_out = 1'b1;
                     bus.mar_in    = 1'b1;
                  end
                  OP_LDI: begin
                     bus.instr_out = 1'b1;
                     bus.reg_a_in  = 1'b1;
                  end
                  OP_JMP: begin
                     bus.instr_out = 1'b1;
                     bus.pc_jmp    = 1'b1;
                  end
                  OP_JC: begin
                     bus.instr_out = bus.flags[0];
                     bus.pc_jmp    = bus.flags[0];
                  end
                  OP_JZ: begin
                     bus.instr_out = bus.flags[1];
                     bus.pc_jmp    = bus.flags[1];
                  end
                  OP_OUT: begin
                     bus.reg_a_out = 1'b1;
                     bus.reg_out   = 1'b1;
                  end
                  default: ;
               endcase
            end
            T3: begin
               case (bus.opcode)
                  OP_LDA: begin
                     bus.ram_out  = 1'b1;
                     bus.reg_a_in = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     bus.ram_out  = 1'b1;
                     bus.reg_b_in = 1'b1;
                  end
                  OP_STA: begin
                     bus.reg_a_out = 1'b1;
                     bus.ram_in    = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                  bus.alu_out      = 1'b1;
                  bus.reg_a_in     = 1'b1;
                  bus.alu_sub      = (bus.opcode == OP_SUB);
                  bus.reg_flags_in = 4'b0011;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Scoreboard bench for sap1_control_sequencer: directed per-cycle vectors queued by the driver, checked by a monitor.
module tb_sap1_control_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sap1_control_sequencer_if bus ();
   sap1_control_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   localparam logic [15:0] HT = 16'h8000, AI = 16'h4000, AO = 16'h2000, BI = 16'h1000;
   localparam logic [15:0] BO = 16'h0800, EO = 16'h0400, SU = 16'h0200, II = 16'h0100;
   localparam logic [15:0] IO = 16'h0080, MI = 16'h0040, RI = 16'h0020, RO = 16'h0010;
   localparam logic [15:0] OI = 16'h0008, CE = 16'h0004, CO = 16'h0002, JP = 16'h0001;
   localparam logic [15:0] F0 = CO | MI;
   localparam logic [15:0] F1 = RO | II | CE;

`ifdef SEQ_EARLY_END_EN
   localparam int L_SHORT = 3;
   localparam int L_MEM   = 4;
`else
   localparam int L_SHORT = 5;
   localparam int L_MEM   = 5;
`endif
   localparam int L_ALU = 5;

   typedef struct {
      logic [15:0] ctl;
      logic [3:0]  fin;
      logic [3:0]  step;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   function automatic logic [15:0] actual_ctl();
      return {bus.halt, bus.reg_a_in, bus.reg_a_out, bus.reg_b_in, bus.reg_b_out,
              bus.alu_out, bus.alu_sub, bus.instr_in, bus.instr_out, bus.mar_in,
              bus.ram_in, bus.ram_out, bus.reg_out, bus.pc_inc, bus.pc_out, bus.pc_jmp};
   endfunction

   // Monitor: pops one expectation per cycle and checks outputs plus the single-bus-driver rule.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            exp_t e;
            logic [15:0] c;
            int drivers;
            e = exp_q.pop_front();
            c = actual_ctl();
            checks++;
            if (c === e.ctl && bus.reg_flags_in === e.fin && bus.step_out === e.step)
               passes++;
            else
               $display("FAIL %s: got ctl=%h fin=%b step=%0d, want ctl=%h fin=%b step=%0d",
                        e.name, c, bus.reg_flags_in, bus.step_out, e.ctl, e.fin, e.step);
            drivers = int'(bus.reg_a_out) + int'(bus.reg_b_out) + int'(bus.alu_out) +
                      int'(bus.instr_out) + int'(bus.ram_out) + int'(bus.pc_out);
            checks++;
            if (drivers <= 1)
               passes++;
            else
               $display("FAIL %s_bus: got %0d drivers, want at most 1", e.name, drivers);
         end
      end
   end

   task automatic cyc(input logic r, input logic p, input logic [3:0] op, input logic [3:0] fl,
                      input logic [15:0] c, input logic [3:0] fi, input logic [3:0] st,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      bus.pr_mode = p;
      bus.opcode  = op;
      bus.flags   = fl;
      e.ctl  = c;
      e.fin  = fi;
      e.step = st;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic instr(input logic [3:0] op, input logic [3:0] fl, input logic [15:0] c2,
                        input logic [15:0] c3, input logic [15:0] c4, input logic [3:0] fi4,
                        input int n, input string nm);
      for (int s = 0; s < n; s++) begin
         logic [15:0] c;
         logic [3:0]  fi;
         logic [3:0]  st;
         c  = (s == 0) ? F0 : (s == 1) ? F1 : (s == 2) ? c2 : (s == 3) ? c3 : c4;
         fi = (s == 4) ? fi4 : 4'b0000;
         st = s[3:0];
         cyc(1'b1, 1'b0, op, fl, c, fi, st, $sformatf("%s_t%0d", nm, s));
      end
   endtask

   initial begin
      bus.pr_mode = 1'b0;
      bus.opcode  = 4'd0;
      bus.flags   = 4'd0;
      repeat (3) cyc(1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 4'b0, 4'd0, "reset");

      // LDI, LDA, ADD back to back: step_out counts each instruction's length
      instr(4'd5, 4'd0, IO | AI, 16'h0, 16'h0, 4'b0, L_SHORT, "ldi");
      instr(4'd1, 4'd0, IO | MI, RO | AI, 16'h0, 4'b0, L_MEM, "lda");
      instr(4'd2, 4'd0, IO | MI, RO | BI, EO | AI, 4'b0011, L_ALU, "add");
      instr(4'd3, 4'd0, IO | MI, RO | BI, EO | AI | SU, 4'b0011, L_ALU, "sub");
      instr(4'd4, 4'd0, IO | MI, AO | RI, 16'h0, 4'b0, L_MEM, "sta");
      instr(4'd6, 4'd0, IO | JP, 16'h0, 16'h0, 4'b0, L_SHORT, "jmp");
      instr(4'd7, 4'b0001, IO | JP, 16'h0, 16'h0, 4'b0, L_SHORT, "jc_taken");
      instr(4'd7, 4'b0010, 16'h0, 16'h0, 16'h0, 4'b0, L_SHORT, "jc_untaken");
      instr(4'd8, 4'b0011, IO | JP, 16'h0, 16'h0, 4'b0, L_SHORT, "jz_taken");
      instr(4'd8, 4'b0001, 16'h0, 16'h0, 16'h0, 4'b0, L_SHORT, "jz_untaken");
      instr(4'd14, 4'd0, AO | OI, 16'h0, 16'h0, 4'b0, L_SHORT, "out");
      instr(4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 4'b0, L_SHORT, "nop");
      instr(4'd11, 4'd0, 16'h0, 16'h0, 16'h0, 4'b0, L_SHORT, "undef");

      // Reset in the middle of ADD
      cyc(1'b1, 1'b0, 4'd2, 4'd0, F0, 4'b0, 4'd0, "rstmid_t0");
      cyc(1'b1, 1'b0, 4'd2, 4'd0, F1, 4'b0, 4'd1, "rstmid_t1");
      cyc(1'b1, 1'b0, 4'd2, 4'd0, IO | MI, 4'b0, 4'd2, "rstmid_t2");
      cyc(1'b0, 1'b0, 4'd2, 4'd0, 16'h0, 4'b0, 4'd0, "rstmid_low");
      instr(4'd1, 4'd0, IO | MI, RO | AI, 16'h0, 4'b0, L_MEM, "after_rst");

      // Programming mode entered during T3 of LDA
      cyc(1'b1, 1'b0, 4'd1, 4'd0, F0, 4'b0, 4'd0, "pr_t0");
      cyc(1'b1, 1'b0, 4'd1, 4'd0, F1, 4'b0, 4'd1, "pr_t1");
      cyc(1'b1, 1'b0, 4'd1, 4'd0, IO | MI, 4'b0, 4'd2, "pr_t2");
      cyc(1'b1, 1'b1, 4'd1, 4'd0, 16'h0, 4'b0, 4'd3, "pr_t3");
      cyc(1'b1, 1'b1, 4'd1, 4'd0, 16'h0, 4'b0, 4'd0, "pr_hold");
      instr(4'd6, 4'd0, IO | JP, 16'h0, 16'h0, 4'b0, L_SHORT, "after_pr");

      // Reset and programming mode together
      cyc(1'b0, 1'b1, 4'd2, 4'd0, 16'h0, 4'b0, 4'd0, "rst_pr");
      instr(4'd5, 4'd0, IO | AI, 16'h0, 16'h0, 4'b0, L_SHORT, "after_rst_pr");

      // Halt holds at T2 regardless of opcode until reset
      cyc(1'b1, 1'b0, 4'd15, 4'd0, F0, 4'b0, 4'd0, "hlt_t0");
      cyc(1'b1, 1'b0, 4'd15, 4'd0, F1, 4'b0, 4'd1, "hlt_t1");
      cyc(1'b1, 1'b0, 4'd15, 4'd0, HT, 4'b0, 4'd2, "hlt_t2");
      for (int i = 0; i < 20; i++)
         cyc(1'b1, 1'b0, (i < 10) ? 4'd15 : 4'd2, 4'd3, HT, 4'b0, 4'd2, "halted");
      cyc(1'b0, 1'b0, 4'd2, 4'd0, 16'h0, 4'b0, 4'd0, "hlt_rst");
      instr(4'd2, 4'd0, IO | MI, RO | BI, EO | AI, 4'b0011, L_ALU, "after_hlt");

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
